// File: rtl/cam_fb_pkg.sv
// Shared frame-buffer definitions used by the camera writer and the QVGA display reader.
package cam_fb_pkg;

    localparam int QVGA_H    = 320;
    localparam int QVGA_V    = 240;
    localparam int FB_ADDR_W = 17;
    localparam int FB_DEPTH  = 76800;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic [1:0] {
        WAIT_VS = 2'd0,
        VS_HIGH = 2'd1,
        ACTIVE  = 2'd2
    } fw_state_e;

    function automatic rgb565_t pack_rgb565(input logic [7:0] hi, input logic [7:0] lo);
        return rgb565_t'({hi, lo});
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Registers camera VSYNC/HREF and flags their edges against the previous sample.
module sync_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic vsync_i,
    input  logic href_i,
    output logic vs_rise_o,
    output logic vs_fall_o,
    output logic hr_fall_o
);

    logic vsync_q;
    logic href_q;

    // previous-cycle copies of the sync inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else begin
            vsync_q <= vsync_i;
            href_q  <= href_i;
        end
    end

    assign vs_rise_o = vsync_i & ~vsync_q;
    assign vs_fall_o = ~vsync_i & vsync_q;
    assign hr_fall_o = ~href_i & href_q;

endmodule

// File: rtl/ov7670_frame_writer.sv
// OV7670 byte-pair capture into a linear y*H_PIXELS+x RGB565 frame buffer.
// Optional FRAME_WRITER_ERR_EN adds a sticky line_err output for malformed lines/frames.
module ov7670_frame_writer
    import cam_fb_pkg::*;
#(
    parameter int H_PIXELS = QVGA_H,
    parameter int V_LINES  = QVGA_V,
    parameter int ADDR_W   = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        data,
    output logic              wclk,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [15:0]       wData,
    output logic              frame_done
`ifdef FRAME_WRITER_ERR_EN
    ,
    output logic              line_err
`endif
);

    localparam int XW = $clog2(H_PIXELS + 1);
    localparam int YW = $clog2(V_LINES + 1);
    localparam logic [XW-1:0]     X_MAX     = XW'(H_PIXELS);
    localparam logic [YW-1:0]     Y_MAX     = YW'(V_LINES);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIXELS);

    fw_state_e         state_q, state_d;
    logic              phase_q, phase_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [7:0]        hi_q, hi_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    rgb565_t           wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              vs_rise, vs_fall, hr_fall;
`ifdef FRAME_WRITER_ERR_EN
    logic              x_ovf_q, x_ovf_d;
    logic              y_ovf_q, y_ovf_d;
    logic              err_q, err_d;
`endif

    sync_edge_det u_edge (
        .clk       (clk),
        .reset_n   (reset_n),
        .vsync_i   (vsync),
        .href_i    (href),
        .vs_rise_o (vs_rise),
        .vs_fall_o (vs_fall),
        .hr_fall_o (hr_fall)
    );

    // frame FSM, byte pairing and line bookkeeping; line_base advances by addition only
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        x_d     = x_q;
        y_d     = y_q;
        base_d  = base_q;
        hi_d    = hi_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
`ifdef FRAME_WRITER_ERR_EN
        x_ovf_d = x_ovf_q;
        y_ovf_d = y_ovf_q;
        err_d   = vs_fall ? 1'b0 : err_q;
`endif
        case (state_q)
            WAIT_VS: begin
                if (vs_rise) state_d = VS_HIGH;
                else         state_d = WAIT_VS;
            end
            VS_HIGH: begin
                if (vs_fall) begin
                    state_d = ACTIVE;
                    phase_d = 1'b0;
                    x_d     = '0;
                    y_d     = '0;
                    base_d  = '0;
`ifdef FRAME_WRITER_ERR_EN
                    x_ovf_d = 1'b0;
                    y_ovf_d = 1'b0;
`endif
                end else begin
                    state_d = VS_HIGH;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    // frame end wins over any byte arriving in the same cycle
                    state_d = VS_HIGH;
                    done_d  = 1'b1;
`ifdef FRAME_WRITER_ERR_EN
                    if (y_q != Y_MAX || y_ovf_q) err_d = 1'b1;
                    else                         err_d = err_q;
`endif
                end else if (href) begin
                    if (!phase_q) begin
                        hi_d    = data;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (x_q < X_MAX && y_q < Y_MAX) begin
                            we_d    = 1'b1;
                            addr_d  = base_q + ADDR_W'(x_q);
                            wdata_d = pack_rgb565(hi_q, data);
                        end else begin
                            we_d = 1'b0;
                        end
                        if (x_q < X_MAX) begin
                            x_d = x_q + XW'(1);
                        end else begin
                            x_d = x_q;
`ifdef FRAME_WRITER_ERR_EN
                            x_ovf_d = 1'b1;
`endif
                        end
                    end
                end else if (hr_fall) begin
                    x_d     = '0;
                    phase_d = 1'b0;
                    if (x_q != '0) begin
                        if (y_q < Y_MAX) begin
                            y_d    = y_q + YW'(1);
                            base_d = base_q + LINE_STEP;
                        end else begin
                            y_d = y_q;
`ifdef FRAME_WRITER_ERR_EN
                            y_ovf_d = 1'b1;
`endif
                        end
                    end else begin
                        y_d = y_q;
                    end
`ifdef FRAME_WRITER_ERR_EN
                    x_ovf_d = 1'b0;
                    if (x_q != X_MAX || x_ovf_q) err_d = 1'b1;
                    else                         err_d = err_q;
`endif
                end else begin
                    state_d = ACTIVE;
                end
            end
            default: state_d = WAIT_VS;
        endcase
    end

    // state and registered frame-buffer outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= WAIT_VS;
            phase_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            base_q  <= '0;
            hi_q    <= 8'h00;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
`ifdef FRAME_WRITER_ERR_EN
            x_ovf_q <= 1'b0;
            y_ovf_q <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            x_q     <= x_d;
            y_q     <= y_d;
            base_q  <= base_d;
            hi_q    <= hi_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
`ifdef FRAME_WRITER_ERR_EN
            x_ovf_q <= x_ovf_d;
            y_ovf_q <= y_ovf_d;
            err_q   <= err_d;
`endif
        end
    end

    assign wclk       = clk;
    assign we         = we_q;
    assign wAddr      = addr_q;
    assign wData      = wdata_q;
    assign frame_done = done_q;
`ifdef FRAME_WRITER_ERR_EN
    assign line_err   = err_q;
`endif

endmodule
